// File: rtl/kmeans_frame_sequencer.sv
// Per-frame controller for the k-means centroid datapath. It seeds the datapath, gates one frame
// of pixels into it, tabulates, then waits for the centroids and publishes them.
module kmeans_frame_sequencer #(
    parameter int unsigned H_ACTIVE       = 1280,
    parameter int unsigned V_ACTIVE       = 720,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [1:0]  num_players_in,
    input  logic        frame_start_in,
    input  logic        frame_end_in,
    input  logic        pix_valid_in,
    output logic        km_valid_out,
    output logic        km_tabulate_out,
    output logic        km_rst_out,
    input  logic        km_done_in,
    input  logic [43:0] km_x_in,
    input  logic [39:0] km_y_in,
    output logic        seed_load_out,
    output logic [43:0] seed_x_out,
    output logic [9:0]  seed_y_out,
    output logic [43:0] x_out,
    output logic [39:0] y_out,
    output logic [3:0]  player_mask_out,
    output logic        valid_out,
    output logic        timeout_out,
    output logic [7:0]  frames_skipped_out
);

    localparam int unsigned TimerW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT_CYCLES - 1);
    localparam logic [9:0] SeedY = 10'(V_ACTIVE / 2);

    typedef enum logic [2:0] {StSeed, StArm, StCollect, StTab, StWait} state_e;

    state_e             state_q, state_d;
    logic [1:0]         active_q;
    logic [3:0]         mask_q;
    logic [43:0]        seed_x_q;
    logic [9:0]         seed_y_q;
    logic [TimerW-1:0]  timer_q;
    logic [43:0]        x_q, cap_x;
    logic [39:0]        y_q, cap_y;
    logic               valid_q;
    logic               timeout_q;
    logic [7:0]         skipped_q;
    logic               skip_inc;
    logic               players_same;
    logic               timer_expired;

    // Seed x sits at the centre of each of N equal-width vertical strips.
    function automatic logic [43:0] seed_for(input logic [1:0] np);
        logic [43:0] s;
        s = '0;
        case (np)
            2'd0: s[10:0] = 11'(H_ACTIVE / 2);
            2'd1: begin
                s[10:0]  = 11'(H_ACTIVE / 4);
                s[21:11] = 11'((3 * H_ACTIVE) / 4);
            end
            2'd2: begin
                s[10:0]  = 11'(H_ACTIVE / 6);
                s[21:11] = 11'((3 * H_ACTIVE) / 6);
                s[32:22] = 11'((5 * H_ACTIVE) / 6);
            end
            default: begin
                s[10:0]  = 11'(H_ACTIVE / 8);
                s[21:11] = 11'((3 * H_ACTIVE) / 8);
                s[32:22] = 11'((5 * H_ACTIVE) / 8);
                s[43:33] = 11'((7 * H_ACTIVE) / 8);
            end
        endcase
        return s;
    endfunction

    function automatic logic [3:0] mask_for(input logic [1:0] np);
        logic [3:0] m;
        for (int i = 0; i < 4; i++) begin
            m[i] = (2'(i) <= np);
        end
        return m;
    endfunction

    assign players_same  = (num_players_in == active_q);
    assign timer_expired = (timer_q == TimerLast);
    // A start that lands while busy, or together with the end it would follow, loses its frame.
    assign skip_inc = frame_start_in && ((state_q == StWait) || (state_q == StTab) ||
                                         ((state_q == StCollect) && frame_end_in));

    always_comb begin
        cap_x = '0;
        cap_y = '0;
        for (int i = 0; i < 4; i++) begin
            if (2'(i) <= active_q) begin
                cap_x[i*11 +: 11] = km_x_in[i*11 +: 11];
                cap_y[i*10 +: 10] = km_y_in[i*10 +: 10];
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= StSeed;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StSeed:    state_d = StArm;
            StArm:     if (frame_start_in) state_d = players_same ? StCollect : StSeed;
            StCollect: if (frame_end_in) state_d = StTab;
            StTab:     state_d = StWait;
            StWait: begin
                if (km_done_in) begin
                    state_d = StArm;
                end else if (timer_expired) begin
                    state_d = StSeed;
                end
            end
            default:   state_d = StSeed;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            active_q  <= '0;
            mask_q    <= '0;
            seed_x_q  <= '0;
            seed_y_q  <= '0;
            timer_q   <= '0;
            x_q       <= '0;
            y_q       <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            skipped_q <= '0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                StSeed: begin
                    active_q <= num_players_in;
                    mask_q   <= mask_for(num_players_in);
                    seed_x_q <= seed_for(num_players_in);
                    seed_y_q <= SeedY;
                end
                StTab: timer_q <= '0;
                StWait: begin
                    timer_q <= timer_q + 1'b1;
                    if (km_done_in) begin
                        x_q     <= cap_x;
                        y_q     <= cap_y;
                        valid_q <= 1'b1;
                    end else if (timer_expired) begin
                        timeout_q <= 1'b1;
                    end
                end
                default: ;
            endcase
            if (skip_inc && (skipped_q != 8'hff)) begin
                skipped_q <= skipped_q + 8'd1;
            end
        end
    end

    always_comb begin
        km_valid_out       = 1'b0;
        km_tabulate_out    = 1'b0;
        seed_load_out      = 1'b0;
        seed_x_out         = seed_x_q;
        seed_y_out         = seed_y_q;
        player_mask_out    = mask_q;
        x_out              = x_q;
        y_out              = y_q;
        valid_out          = valid_q;
        timeout_out        = timeout_q;
        frames_skipped_out = skipped_q;
        case (state_q)
            StSeed: begin
                seed_load_out   = 1'b1;
                seed_x_out      = seed_for(num_players_in);
                seed_y_out      = SeedY;
                player_mask_out = mask_for(num_players_in);
            end
            // The frame_start cycle already belongs to the frame being collected.
            StArm:     km_valid_out = pix_valid_in && frame_start_in && players_same;
            StCollect: km_valid_out = pix_valid_in;
            StTab:     km_tabulate_out = 1'b1;
            default: ;
        endcase
        km_rst_out = rst_in || (state_q == StSeed);
        if (rst_in) begin
            km_valid_out       = 1'b0;
            km_tabulate_out    = 1'b0;
            seed_load_out      = 1'b0;
            seed_x_out         = '0;
            seed_y_out         = '0;
            player_mask_out    = '0;
            x_out              = '0;
            y_out              = '0;
            valid_out          = 1'b0;
            timeout_out        = 1'b0;
            frames_skipped_out = '0;
        end
    end

endmodule
